serial_word_adder_ctrl: RTL

Multi-precision add sequencer that sits directly upstream of the team's 3-bit ripple-carry adder and also consumes its output.
- Accepts NUM_WORDS operand word pairs, least-significant word first, over a valid/ready handshake.
- Drives each pair into the external 3-bit adder with the carry from the previous word.
- Registers each sum word and the running carry.
- Presents result words on an output valid/ready handshake and reports the final carry.

---
 rtl/serial_add_pkg.sv | 22 ++
 rtl/out_skid_reg.sv | 43 ++++
 rtl/serial_word_adder_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the multi-precision serial add sequencer.
// Holds the sequencer state encoding, default word geometry and the
// index-width helper used to size word_idx.
package serial_add_pkg;

   localparam int WORD_W_DEF    = 3;
   localparam int NUM_WORDS_DEF = 4;

   // Sequencer states: IDLE waits for start, RUN accepts operand words,
   // DRAIN waits for the last result word to leave the output buffer.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Width needed to index num_words words, never less than one bit.
   function automatic int idx_width(input int num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage

// File: rtl/out_skid_reg.sv
// One-entry output buffer holding a result word and its index.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds contents while out_valid && !out_ready; refills in the
// same cycle it drains, so a word per cycle flows when out_ready stays high.
// Ports: load/load_sum/load_idx write the entry, sum_out/word_idx/out_valid
// present it, out_ready pops it, out_space says a load may happen this cycle.
module out_skid_reg
   import serial_add_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int IDX_W  = idx_width(NUM_WORDS_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_sum,
   input  logic [IDX_W-1:0]  load_idx,
   input  logic              out_ready,
   output logic [WORD_W-1:0] sum_out,
   output logic [IDX_W-1:0]  word_idx,
   output logic              out_valid,
   output logic              out_space
);

   // Empty, or being emptied this cycle: the only comb path from out_ready.
   assign out_space = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_out   <= '0;
         word_idx  <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         // A load coinciding with a pop replaces the entry; valid stays up.
         sum_out   <= load_sum;
         word_idx  <= load_idx;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_adder_ctrl.sv
// Multi-precision add sequencer feeding an external WORD_W-bit adder, LS word first.
// Latency: 1 cycle from operand accept to out_valid; done 1 cycle after the last output handshake.
// Backpressure: in_ready drops while the output buffer is full and out_ready is low.
// Ports: start/cin_init begin an operation; a_in/b_in/in_valid/in_ready carry operand
// words; add_* connect to the adder; sum_out/word_idx/out_valid/out_ready carry results;
// carry_out is the final carry, busy covers RUN and DRAIN, done pulses at completion.
module serial_word_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int NUM_WORDS = NUM_WORDS_DEF,
   parameter int IDX_W     = idx_width(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cin_init,
   input  logic [WORD_W-1:0] a_in,
   input  logic [WORD_W-1:0] b_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] add_a,
   output logic [WORD_W-1:0] add_b,
   output logic              add_cin,
   input  logic [WORD_W-1:0] add_sum,
   input  logic              add_cout,
   output logic [WORD_W-1:0] sum_out,
   output logic [IDX_W-1:0]  word_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              carry_out,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t            state_q, state_d;
   logic              carry_reg;
   logic [IDX_W-1:0]  idx;
   logic              out_space;
   logic              accept;
   logic              start_ok;
   logic              drain_fire;

   // Adder inputs are driven straight through; only accepting cycles matter.
   assign add_a   = a_in;
   assign add_b   = b_in;
   assign add_cin = carry_reg;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      busy       = 1'b0;
      start_ok   = 1'b0;
      drain_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = out_space;
            if (in_valid && out_space && (idx == LAST_IDX)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (out_valid && out_ready) begin
               drain_fire = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         carry_reg <= 1'b0;
         idx       <= '0;
         carry_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= drain_fire;
         if (start_ok) begin
            carry_reg <= cin_init;
            idx       <= '0;
            carry_out <= 1'b0;
         end else if (accept) begin
            carry_reg <= add_cout;
            idx       <= idx + IDX_W'(1);
         end
         // carry_reg is final once the last word has been accepted.
         if (drain_fire) begin
            carry_out <= carry_reg;
         end
      end
   end

   out_skid_reg #(
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W)
   ) u_out_skid_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_sum  (add_sum),
      .load_idx  (idx),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .word_idx  (word_idx),
      .out_valid (out_valid),
      .out_space (out_space)
   );

endmodule
